// File: rtl/savestate_clock_sequencer.sv
// Savestate clock sequencer: steers the core clock divider (halt/turbo/begin-reset)
// so save/load sequences stop the core on a deterministic 65.536 kHz tick boundary.
module savestate_clock_sequencer #(
    parameter int          LOAD_ALIGN_TICKS = 4,
    parameter logic [23:0] TIMEOUT_CYCLES   = 24'd1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ss_save_req,
    input  logic ss_load_req,
    input  logic ss_abort,
    input  logic cpu_instr_boundary,
    input  logic clk_en_32_768khz,
    input  logic clk_en_65_536khz,
    input  logic ss_data_done,
    output logic ss_halt,
    output logic ss_turbo,
    output logic ss_begin_reset,
    output logic ss_ready,
    output logic ss_busy,
    output logic ss_done,
    output logic ss_error
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RUN,
        LOAD_RESET,
        LOAD_RUN,
        HALTED,
        RELEASE
    } state_t;

    localparam logic [3:0]  ALIGN   = 4'(LOAD_ALIGN_TICKS);
    localparam logic [23:0] TO_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t      state, nxt;
    logic        err_nxt;
    logic [23:0] cyc_cnt;
    logic [3:0]  tick_cnt;
    logic [3:0]  tick_inc;
    logic        timeout;

    assign tick_inc = (tick_cnt == 4'hF) ? tick_cnt : tick_cnt + 4'd1;
    assign timeout  = (cyc_cnt == TO_LAST);

    always_comb begin
        nxt     = state;
        err_nxt = 1'b0;
        if (state != IDLE && ss_abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Save wins a simultaneous request; the load is dropped.
                    if (ss_save_req)      nxt = SAVE_RUN;
                    else if (ss_load_req) nxt = LOAD_RESET;
                end
                SAVE_RUN: begin
                    if (clk_en_65_536khz && cpu_instr_boundary) begin
                        nxt = HALTED;
                    end else if (timeout) begin
                        nxt     = IDLE;
                        err_nxt = 1'b1;
                    end
                end
                LOAD_RESET: nxt = LOAD_RUN;
                LOAD_RUN: begin
                    // The first tick after the divider reload must land on a full 32 kHz tick.
                    if (clk_en_65_536khz && tick_cnt == 4'd0 && !clk_en_32_768khz) begin
                        nxt     = IDLE;
                        err_nxt = 1'b1;
                    end else if (clk_en_65_536khz && tick_inc == ALIGN) begin
                        nxt = HALTED;
                    end else if (timeout) begin
                        nxt     = IDLE;
                        err_nxt = 1'b1;
                    end
                end
                HALTED: begin
                    if (ss_data_done) nxt = RELEASE;
                end
                RELEASE: nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cyc_cnt        <= '0;
            tick_cnt       <= '0;
            ss_halt        <= 1'b0;
            ss_turbo       <= 1'b0;
            ss_begin_reset <= 1'b0;
            ss_ready       <= 1'b0;
            ss_busy        <= 1'b0;
            ss_done        <= 1'b0;
            ss_error       <= 1'b0;
        end else begin
            state <= nxt;
            if (state != SAVE_RUN && state != LOAD_RUN) cyc_cnt <= '0;
            else                                        cyc_cnt <= cyc_cnt + 24'd1;
            if (state == LOAD_RESET)                            tick_cnt <= '0;
            else if (state == LOAD_RUN && clk_en_65_536khz)     tick_cnt <= tick_inc;
            // Turbo stays high through HALTED so the divider never sees a fresh rising edge.
            ss_halt        <= (nxt == HALTED);
            ss_turbo       <= (nxt == SAVE_RUN) || (nxt == LOAD_RESET) ||
                              (nxt == LOAD_RUN) || (nxt == HALTED);
            ss_begin_reset <= (nxt == LOAD_RESET);
            ss_ready       <= (nxt == HALTED);
            ss_busy        <= (nxt != IDLE) && (nxt != RELEASE);
            ss_done        <= (nxt == RELEASE);
            ss_error       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_savestate_clock_sequencer.sv
// Bench for savestate_clock_sequencer: directed scenarios plus random traffic, each
// cycle checked against a phase-level reference model of the sequencing rules.
module tb_savestate_clock_sequencer;

    localparam int ALIGN = 4;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ss_save_req = 1'b0, ss_load_req = 1'b0, ss_abort = 1'b0;
    logic cpu_instr_boundary = 1'b0, clk_en_32_768khz = 1'b0, clk_en_65_536khz = 1'b0;
    logic ss_data_done = 1'b0;
    logic ss_halt, ss_turbo, ss_begin_reset, ss_ready, ss_busy, ss_done, ss_error;
    logic [6:0] outs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    savestate_clock_sequencer #(
        .LOAD_ALIGN_TICKS(ALIGN),
        .TIMEOUT_CYCLES  (24'(TO))
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ss_save_req       (ss_save_req),
        .ss_load_req       (ss_load_req),
        .ss_abort          (ss_abort),
        .cpu_instr_boundary(cpu_instr_boundary),
        .clk_en_32_768khz  (clk_en_32_768khz),
        .clk_en_65_536khz  (clk_en_65_536khz),
        .ss_data_done      (ss_data_done),
        .ss_halt           (ss_halt),
        .ss_turbo          (ss_turbo),
        .ss_begin_reset    (ss_begin_reset),
        .ss_ready          (ss_ready),
        .ss_busy           (ss_busy),
        .ss_done           (ss_done),
        .ss_error          (ss_error)
    );

    // {halt, turbo, begin_reset, ready, busy, done, error}
    assign outs = {ss_halt, ss_turbo, ss_begin_reset, ss_ready, ss_busy, ss_done, ss_error};

    // Reference model: which phase of a sequence we are in, time spent running, ticks seen.
    localparam int P_IDLE = 0, P_SAVE = 1, P_LRST = 2, P_LRUN = 3, P_HALT = 4, P_REL = 5;
    int phase = P_IDLE;
    int run_cyc = 0;
    int ticks = 0;
    logic [6:0] exp = 7'b0;

    task automatic model_reset();
        phase = P_IDLE; run_cyc = 0; ticks = 0; exp = 7'b0;
    endtask

    task automatic model_clock();
        logic err;
        bit moved;
        err = 1'b0;
        moved = 1'b0;
        if (ss_abort && phase != P_IDLE) phase = P_IDLE;
        else case (phase)
            P_IDLE: begin
                if (ss_save_req) begin phase = P_SAVE; run_cyc = 0; end
                else if (ss_load_req) phase = P_LRST;
            end
            P_SAVE: begin
                if (clk_en_65_536khz && cpu_instr_boundary) phase = P_HALT;
                else if (run_cyc == TO - 1) begin phase = P_IDLE; err = 1'b1; end
                else run_cyc++;
            end
            P_LRST: begin phase = P_LRUN; run_cyc = 0; ticks = 0; end
            P_LRUN: begin
                if (clk_en_65_536khz) begin
                    if (ticks == 0 && !clk_en_32_768khz) begin
                        phase = P_IDLE; err = 1'b1; moved = 1'b1;
                    end else begin
                        ticks = (ticks < 15) ? ticks + 1 : 15;
                        if (ticks == ALIGN) begin phase = P_HALT; moved = 1'b1; end
                    end
                end
                if (!moved) begin
                    if (run_cyc == TO - 1) begin phase = P_IDLE; err = 1'b1; end
                    else run_cyc++;
                end
            end
            P_HALT: if (ss_data_done) phase = P_REL;
            default: phase = P_IDLE;
        endcase
        case (phase)
            P_SAVE, P_LRUN: exp = 7'b0100100;
            P_LRST:         exp = 7'b0110100;
            P_HALT:         exp = 7'b1101100;
            P_REL:          exp = 7'b0000010;
            default:        exp = {6'b0, err};
        endcase
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle outputs.
    task automatic step(input logic sv, input logic ld, input logic ab, input logic bd,
                        input logic t32, input logic t65, input logic dn);
        ss_save_req = sv; ss_load_req = ld; ss_abort = ab; cpu_instr_boundary = bd;
        clk_en_32_768khz = t32; clk_en_65_536khz = t65; ss_data_done = dn;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ss_save_req = 1'b1;
        #3;
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL reset_async: got %b want %b", outs, 7'b0); end
        @(posedge clk); @(posedge clk); #1;
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL reset_held: got %b want %b", outs, 7'b0); end
        ss_save_req = 1'b0;
        model_reset();
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== exp) begin miscompares++; $display("FAIL reset_idle: got %b want %b", outs, exp); end
    endtask

    task automatic test_save();
        int nt;
        logic t65;
        nt = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0100100) begin miscompares++; $display("FAIL save_turbo: got %b want %b", outs, 7'b0100100); end
        for (int k = 0; k < 12; k++) begin
            t65 = (k % 3 == 2);
            if (t65) nt++;
            step(0, 0, 0, t65 && nt == 4, t65, t65, 0);
            vectors++;
            if (outs !== exp) begin miscompares++; $display("FAIL save_run k=%0d: got %b want %b", k, outs, exp); end
        end
        vectors++;
        if (outs !== 7'b1101100) begin miscompares++; $display("FAIL save_halted: got %b want %b", outs, 7'b1101100); end
        step(0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (outs !== 7'b0000010) begin miscompares++; $display("FAIL save_release: got %b want %b", outs, 7'b0000010); end
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL save_idle: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_load();
        logic t65;
        step(0, 1, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0110100) begin miscompares++; $display("FAIL load_begin: got %b want %b", outs, 7'b0110100); end
        step(0, 0, 0, 0, 1, 1, 0);
        vectors++;
        if (outs !== 7'b0100100) begin miscompares++; $display("FAIL load_run: got %b want %b", outs, 7'b0100100); end
        for (int k = 0; k < 8; k++) begin
            t65 = (k % 2 == 1);
            step(0, 0, 0, 0, t65 && (k == 1 || k == 5), t65, 0);
            vectors++;
            if (outs !== exp) begin miscompares++; $display("FAIL load_tick k=%0d: got %b want %b", k, outs, exp); end
        end
        vectors++;
        if (outs !== 7'b1101100) begin miscompares++; $display("FAIL load_halted: got %b want %b", outs, 7'b1101100); end
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL load_idle: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_load_misalign();
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        vectors++;
        if (outs !== 7'b0000001) begin miscompares++; $display("FAIL misalign_err: got %b want %b", outs, 7'b0000001); end
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL misalign_idle: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_timeout();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= TO; k++) begin
            step(0, 0, 0, 0, k % 2 == 1, k % 2 == 1, 0);
            vectors++;
            if (outs !== (k == TO ? 7'b0000001 : 7'b0100100)) begin
                miscompares++;
                $display("FAIL timeout k=%0d: got %b want %b", k, outs, (k == TO ? 7'b0000001 : 7'b0100100));
            end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL timeout_idle: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0100100) begin miscompares++; $display("FAIL both_req: got %b want %b", outs, 7'b0100100); end
        step(0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b1101100) begin miscompares++; $display("FAIL req_in_halt: got %b want %b", outs, 7'b1101100); end
        step(0, 0, 0, 0, 1, 1, 1);
        vectors++;
        if (outs !== 7'b0000010) begin miscompares++; $display("FAIL b2b_release: got %b want %b", outs, 7'b0000010); end
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_abort();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL abort_save: got %b want %b", outs, 7'b0); end
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL abort_load: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        vectors++;
        if (outs !== 7'b1101100) begin miscompares++; $display("FAIL areset_pre: got %b want %b", outs, 7'b1101100); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL areset_drop: got %b want %b", outs, 7'b0); end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 7'b0) begin miscompares++; $display("FAIL areset_idle: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_random();
        logic t65;
        for (int k = 0; k < 800; k++) begin
            t65 = ($urandom % 3 == 0);
            step($urandom % 10 == 0, $urandom % 10 == 0, $urandom % 60 == 0, $urandom % 3 == 0,
                 t65 && ($urandom % 10 < 7), t65, $urandom % 5 == 0);
            vectors++;
            if (outs !== exp) begin miscompares++; $display("FAIL random k=%0d: got %b want %b", k, outs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_save();
        test_load();
        test_load_misalign();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
